// File: rtl/mem_access_stage.sv
// Memory-access stage: passes ALU results through and runs loads/stores over a req/ack data-memory port.
// Optional DMEM_TIMEOUT_EN: aborts an access after TIMEOUT_CYCLES without ack and raises sticky dmem_err_out.
module mem_access_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] store_data_in,
    input  logic [2:0]            reg_addr_in,
    input  logic [1:0]            mem_ctrl_in,
    input  logic [1:0]            wb_ctrl_in,
    output logic                  stall_out,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
`ifdef DMEM_TIMEOUT_EN
    output logic                  dmem_err_out,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            reg_addr_out,
    output logic [1:0]            wb_ctrl_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state;
    logic                    cap_we;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [DATA_WIDTH-1:0]   cap_alu;
    logic [2:0]              cap_reg;
    logic [1:0]              cap_wb;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        wait_cnt;
`endif

    // Memory port and stall are decoded from state and capture registers only.
    assign stall_out  = (state == ACCESS);
    assign dmem_req   = (state == ACCESS);
    assign dmem_we    = cap_we;
    assign dmem_addr  = cap_addr;
    assign dmem_wdata = cap_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_alu      <= '0;
            cap_reg      <= '0;
            cap_wb       <= '0;
            data_out     <= '0;
            reg_addr_out <= '0;
            wb_ctrl_out  <= '0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt     <= '0;
            dmem_err_out <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!valid_in) begin
                        wb_ctrl_out <= 2'b00;
                    end else if (mem_ctrl_in == 2'b00) begin
                        data_out     <= alu_result_in;
                        reg_addr_out <= reg_addr_in;
                        wb_ctrl_out  <= wb_ctrl_in;
                    end else begin
                        // Read wins when both control bits are set.
                        cap_we      <= (mem_ctrl_in == 2'b10);
                        cap_addr    <= alu_result_in[ADDR_WIDTH-1:0];
                        cap_wdata   <= store_data_in;
                        cap_alu     <= alu_result_in;
                        cap_reg     <= reg_addr_in;
                        cap_wb      <= wb_ctrl_in;
                        wb_ctrl_out <= 2'b00;
                        state       <= ACCESS;
`ifdef DMEM_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                ACCESS: begin
                    wb_ctrl_out <= 2'b00;
                    if (dmem_ack) begin
                        data_out     <= cap_we ? cap_alu : dmem_rdata;
                        reg_addr_out <= cap_reg;
                        wb_ctrl_out  <= cap_wb;
                        state        <= IDLE;
`ifdef DMEM_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: bubble out and flag the error until reset.
                        dmem_err_out <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
